fila_escrita_registradores: RTL and testbench

Write-back queue directly upstream of the 16x32 register bank. It buffers results from the execute stage and issues at most one write per cycle to the bank's Address_to_write, Data_to_write and Signal_write inputs when the bank permits. A combinational lookup port returns the newest pending value for any address, so readers see queued data before it reaches the bank.

---
 rtl/fila_escrita_registradores.sv | 125 ++++++++++++
 tb/tb_fila_escrita_registradores.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fila_escrita_registradores.sv
`default_nettype none
// ============================================================================
// Module      : fila_escrita_registradores
// Description : Write-back queue in front of the 16x32 register bank.
//               Buffers execute-stage results, issues one bank write per
//               cycle when Drain_enable allows, and offers a combinational
//               lookup of the newest pending value for any register.
//               Optional macro FILA_COALESCE_EN: a push to the same address
//               as the tail-most pending entry overwrites that entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fila_escrita_registradores #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 4   // power of two, at least 2
) (
  input  logic                    Clock_in,
  input  logic                    Signal_reset,
  input  logic                    Push_valid,
  output logic                    Push_ready,
  input  logic [ADDR_WIDTH-1:0]   Push_address,
  input  logic [DATA_WIDTH-1:0]   Push_data,
  input  logic                    Drain_enable,
  output logic [ADDR_WIDTH-1:0]   Address_to_write,
  output logic [DATA_WIDTH-1:0]   Data_to_write,
  output logic                    Signal_write,
  input  logic [ADDR_WIDTH-1:0]   Lookup_address,
  output logic                    Lookup_hit,
  output logic [DATA_WIDTH-1:0]   Lookup_data,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Empty,
  output logic                    Full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  // Entry storage; only occupied slots are ever observed, so no reset needed
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic pop;
  logic push_alloc;
  logic merge;

  assign Count = count;
  assign Empty = (count == '0);
  assign Full  = (count == DEPTH_CNT);

  // Bank strobe and head entry; outputs forced to zero when nothing is queued
  assign Signal_write     = !Empty && Drain_enable;
  assign Address_to_write = Empty ? '0 : mem_addr[head];
  assign Data_to_write    = Empty ? '0 : mem_data[head];
  assign pop              = Signal_write;

`ifdef FILA_COALESCE_EN
  logic [PTR_W-1:0] tail_last;
  logic             tail_match;

  assign tail_last  = tail - PTR_W'(1);
  assign tail_match = !Empty && (mem_addr[tail_last] == Push_address);
  // Merging is only legal if the tail-most entry stays in the queue this
  // cycle; when it is the sole entry and is draining, allocate instead.
  assign merge      = Push_valid && tail_match && !(pop && (count == ONE_CNT));
  assign Push_ready = !Full || tail_match;
`else
  assign merge      = 1'b0;
  assign Push_ready = !Full;
`endif

  assign push_alloc = Push_valid && Push_ready && !merge;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge Clock_in or negedge Signal_reset) begin
    if (!Signal_reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)        head <= head + PTR_W'(1);
      if (push_alloc) tail <= tail + PTR_W'(1);
      case ({push_alloc, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Entry writes: allocate at the tail, or overwrite data of a merged entry
  always_ff @(posedge Clock_in) begin
    if (push_alloc) begin
      mem_addr[tail] <= Push_address;
      mem_data[tail] <= Push_data;
    end
`ifdef FILA_COALESCE_EN
    else if (merge) begin
      mem_data[tail_last] <= Push_data;
    end
`endif
  end

  // Lookup walks oldest to newest so the newest match overwrites older ones
  always_comb begin
    logic [PTR_W-1:0] idx;
    Lookup_hit  = 1'b0;
    Lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem_addr[idx] == Lookup_address)) begin
        Lookup_hit  = 1'b1;
        Lookup_data = mem_data[idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fila_escrita_registradores.sv
`default_nettype none
// ============================================================================
// Module      : tb_fila_escrita_registradores
// Description : Self-checking bench for the register write-back queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fila_escrita_registradores;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int DEP = 4;

  logic            clk;
  logic            rst_n;
  logic            pv;
  logic            push_ready;
  logic [AW-1:0]   pa;
  logic [DW-1:0]   pd;
  logic            de;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            sw;
  logic [AW-1:0]   la;
  logic            lhit;
  logic [DW-1:0]   ldata;
  logic [2:0]      cnt;
  logic            empty;
  logic            full;

  fila_escrita_registradores #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP)) dut (
    .Clock_in         (clk),
    .Signal_reset     (rst_n),
    .Push_valid       (pv),
    .Push_ready       (push_ready),
    .Push_address     (pa),
    .Push_data        (pd),
    .Drain_enable     (de),
    .Address_to_write (waddr),
    .Data_to_write    (wdata),
    .Signal_write     (sw),
    .Lookup_address   (la),
    .Lookup_hit       (lhit),
    .Lookup_data      (ldata),
    .Count            (cnt),
    .Empty            (empty),
    .Full             (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entry_t;

  typedef struct {
    logic valid; logic [AW-1:0] addr; logic [DW-1:0] data; logic drain; logic [AW-1:0] laddr;
    int cnt; logic sw; logic [AW-1:0] wa; logic [DW-1:0] wd; logic rdy; logic hit; logic [DW-1:0] ld;
  } vec_t;

  entry_t        q[$];      // reference queue, oldest at index 0
  entry_t        wlog[$];   // writes seen by the bank
  logic [DW-1:0] bank [16];
  vec_t          tbl [13];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready(input logic [AW-1:0] a);
    logic r;
    r = (q.size() != DEP);
`ifdef FILA_COALESCE_EN
    if (q.size() != 0 && q[q.size()-1].a == a) r = 1'b1;
`endif
    return r;
  endfunction

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic dr, input logic [AW-1:0] l);
    pv = v; pa = a; pd = d; de = dr; la = l;
    #1;
  endtask

  // Compare every output against the reference queue
  task automatic check_model();
    logic          e_hit;
    logic [DW-1:0] e_ld;
    e_hit = 1'b0;
    e_ld  = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!e_hit && q[i].a == la) begin
        e_hit = 1'b1;
        e_ld  = q[i].d;
      end
    end
    chk("count", cnt, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEP);
    chk("push_ready", push_ready, m_ready(pa));
    chk("signal_write", sw, q.size() != 0 && de);
    chk("write_addr", waddr, q.size() != 0 ? q[0].a : '0);
    chk("write_data", wdata, q.size() != 0 ? q[0].d : '0);
    chk("lookup_hit", lhit, e_hit);
    chk("lookup_data", ldata, e_ld);
  endtask

  // Cross one rising edge: update bank from the DUT strobe and the model from the rules
  task automatic advance();
    logic          pop, push, merge, s_sw;
    logic [AW-1:0] s_a;
    logic [DW-1:0] s_d;
    pop   = (q.size() != 0) && de;
    push  = pv && m_ready(pa);
    merge = 1'b0;
`ifdef FILA_COALESCE_EN
    merge = push && q.size() != 0 && q[q.size()-1].a == pa && !(pop && q.size() == 1);
`endif
    s_sw = sw; s_a = waddr; s_d = wdata;
    @(posedge clk);
    if (s_sw === 1'b1 && rst_n) begin
      bank[s_a] = s_d;
      wlog.push_back('{s_a, s_d});
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (merge) q[q.size()-1].d = pd;
      else       q.push_back('{pa, pd});
    end
    @(negedge clk);
  endtask

  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic dr, input logic [AW-1:0] l);
    drive(v, a, d, dr, l);
    check_model();
    advance();
  endtask

  initial begin
    // valid addr data drain laddr | cnt sw wa wd rdy hit ld
    tbl[0]  = '{1'b1, 4'd0, 32'h01, 1'b0, 4'd0, 0, 1'b0, 4'd0, 32'h00, 1'b1, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 4'd0, 32'h00, 1'b1, 4'd0, 1, 1'b1, 4'd0, 32'h01, 1'b1, 1'b1, 32'h01};
    tbl[2]  = '{1'b0, 4'd0, 32'h00, 1'b1, 4'd0, 0, 1'b0, 4'd0, 32'h00, 1'b1, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 4'd1, 32'h11, 1'b0, 4'd1, 0, 1'b0, 4'd0, 32'h00, 1'b1, 1'b0, 32'h00};
    tbl[4]  = '{1'b1, 4'd2, 32'h22, 1'b0, 4'd1, 1, 1'b0, 4'd1, 32'h11, 1'b1, 1'b1, 32'h11};
    tbl[5]  = '{1'b1, 4'd3, 32'h33, 1'b0, 4'd2, 2, 1'b0, 4'd1, 32'h11, 1'b1, 1'b1, 32'h22};
    tbl[6]  = '{1'b1, 4'd4, 32'h44, 1'b0, 4'd4, 3, 1'b0, 4'd1, 32'h11, 1'b1, 1'b0, 32'h00};
    tbl[7]  = '{1'b1, 4'd5, 32'h55, 1'b0, 4'd4, 4, 1'b0, 4'd1, 32'h11, 1'b0, 1'b1, 32'h44};
    tbl[8]  = '{1'b0, 4'd0, 32'h00, 1'b1, 4'd5, 4, 1'b1, 4'd1, 32'h11, 1'b0, 1'b0, 32'h00};
    tbl[9]  = '{1'b0, 4'd0, 32'h00, 1'b1, 4'd1, 3, 1'b1, 4'd2, 32'h22, 1'b1, 1'b0, 32'h00};
    tbl[10] = '{1'b0, 4'd0, 32'h00, 1'b1, 4'd3, 2, 1'b1, 4'd3, 32'h33, 1'b1, 1'b1, 32'h33};
    tbl[11] = '{1'b0, 4'd0, 32'h00, 1'b1, 4'd4, 1, 1'b1, 4'd4, 32'h44, 1'b1, 1'b1, 32'h44};
    tbl[12] = '{1'b0, 4'd0, 32'h00, 1'b1, 4'd4, 0, 1'b0, 4'd0, 32'h00, 1'b1, 1'b0, 32'h00};

    for (int i = 0; i < 16; i++) bank[i] = '0;
    pv = 0; pa = 0; pd = 0; de = 0; la = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_ready", push_ready, 1);
    chk("reset_lookup_hit", lhit, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of operation
    step(1, 4'd1, 32'hAA, 0, 4'd1);
    step(1, 4'd2, 32'hBB, 0, 4'd1);
    drive(0, 4'd0, 32'h0, 1, 4'd1);
    check_model();
    #1 rst_n = 1'b0;
    #1;
    chk("async_count", cnt, 0);
    chk("async_empty", empty, 1);
    chk("async_sw", sw, 0);
    chk("async_waddr", waddr, 0);
    chk("async_wdata", wdata, 0);
    chk("async_hit", lhit, 0);
    #2 rst_n = 1'b1;
    q.delete();
    wlog.delete();
    @(negedge clk);
    repeat (3) step(0, 4'd0, 32'h0, 1, 4'd1);
    chk("no_stale_write", wlog.size(), 0);

    // Single write, then fill / overflow / ordered drain
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].valid, tbl[i].addr, tbl[i].data, tbl[i].drain, tbl[i].laddr);
      chk($sformatf("v%0d_count", i), cnt, tbl[i].cnt);
      chk($sformatf("v%0d_empty", i), empty, tbl[i].cnt == 0);
      chk($sformatf("v%0d_full", i), full, tbl[i].cnt == DEP);
      chk($sformatf("v%0d_sw", i), sw, tbl[i].sw);
      chk($sformatf("v%0d_waddr", i), waddr, tbl[i].wa);
      chk($sformatf("v%0d_wdata", i), wdata, tbl[i].wd);
      chk($sformatf("v%0d_ready", i), push_ready, tbl[i].rdy);
      chk($sformatf("v%0d_hit", i), lhit, tbl[i].hit);
      chk($sformatf("v%0d_ldata", i), ldata, tbl[i].ld);
      advance();
    end
    chk("bank_r0", bank[0], 32'h1);
    chk("bank_r4", bank[4], 32'h44);
    chk("bank_r5_untouched", bank[5], 32'h0);

    // Simultaneous push and pop at Count = 2 with tail wrap
    wlog.delete();
    step(1, 4'd8, 32'h8, 0, 4'd7);
    step(1, 4'd9, 32'h9, 0, 4'd7);
    step(1, 4'd7, 32'h7, 1, 4'd7);
    drive(0, 4'd0, 32'h0, 0, 4'd7);
    chk("pushpop_count", cnt, 2);
    chk("pushpop_hit", lhit, 1);
    chk("pushpop_ldata", ldata, 32'h7);
    repeat (3) step(0, 4'd0, 32'h0, 1, 4'd7);
    chk("pushpop_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("pushpop_first", wlog[0].a, 4'd8);
      chk("pushpop_last", wlog[2].a, 4'd7);
    end
    chk("bank_r7", bank[7], 32'h7);

    // Lookup priority: newest matching entry wins
    step(1, 4'd7, 32'h1, 0, 4'd7);
    step(1, 4'd7, 32'h7, 0, 4'd7);
    drive(0, 4'd0, 32'h0, 0, 4'd7);
    chk("lookup7_hit", lhit, 1);
    chk("lookup7_data", ldata, 32'h7);
    drive(0, 4'd0, 32'h0, 0, 4'd6);
    chk("lookup6_hit", lhit, 0);
    chk("lookup6_data", ldata, 32'h0);
    repeat (3) step(0, 4'd0, 32'h0, 1, 4'd7);

    // Same-address back-to-back pushes
    wlog.delete();
    step(1, 4'd3, 32'hA, 0, 4'd3);
    step(1, 4'd3, 32'hB, 0, 4'd3);
    drive(0, 4'd0, 32'h0, 0, 4'd3);
`ifdef FILA_COALESCE_EN
    chk("same_addr_count", cnt, 1);
`else
    chk("same_addr_count", cnt, 2);
`endif
    repeat (3) step(0, 4'd0, 32'h0, 1, 4'd3);
`ifdef FILA_COALESCE_EN
    chk("same_addr_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) chk("same_addr_only", wlog[0].d, 32'hB);
`else
    chk("same_addr_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("same_addr_first", wlog[0].d, 32'hA);
      chk("same_addr_second", wlog[1].d, 32'hB);
    end
`endif
    chk("bank_r3", bank[3], 32'hB);

    // Randomized traffic against the reference queue
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 2) == 0, AW'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
